// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller among N_REQ read/write clients with round-robin, range check and ack timeout.
// Define SRAM_ARB_WRITE_PRIORITY_EN to serve pending writes ahead of reads, each class with its own rr pointer.
module sram_arbiter #(
  parameter int N_REQ = 2,
  parameter int data_width = 16,
  parameter int sram_addr_width = 12,
  parameter int sram_capacity = 8096,
  parameter int timeout_cycles = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 cl_read_req,
  input  logic [N_REQ-1:0]                 cl_write_req,
  input  logic [N_REQ*sram_addr_width-1:0] cl_read_addr,
  input  logic [N_REQ*sram_addr_width-1:0] cl_write_addr,
  input  logic [N_REQ*data_width-1:0]      cl_write_data,
  output logic [N_REQ-1:0]                 cl_read_ready,
  output logic [N_REQ-1:0]                 cl_write_ready,
  output logic [N_REQ-1:0]                 cl_read_invalid,
  output logic [N_REQ-1:0]                 cl_write_invalid,
  output logic [data_width-1:0]            cl_read_data,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [sram_addr_width-1:0]       mem_addr,
  output logic [data_width-1:0]            mem_wdata,
  input  logic                             mem_ack,
  input  logic [data_width-1:0]            mem_rdata,
  input  logic                             mem_err
);
  localparam int NC = 2 * N_REQ;
  localparam int CW = $clog2(NC);
  localparam int TW = $clog2(timeout_cycles);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [NC-1:0] req_ch, pend, rdy_q, inv_q, rdy_nx, inv_nx;
  logic [sram_addr_width-1:0] ch_addr [NC];
  logic [data_width-1:0] ch_data [NC];
  logic [CW-1:0] cur, pick, ch, ch_nx;
  logic [TW-1:0] tcnt;
  logic [31:0] addr_ext;
  logic grant, oob, done, tmo;
  // channel 2i is client i's read, 2i+1 its write
  for (genvar i = 0; i < N_REQ; i++) begin : g_ch
    assign req_ch[2*i] = cl_read_req[i];
    assign req_ch[2*i+1] = cl_write_req[i];
    assign ch_addr[2*i] = cl_read_addr[i*sram_addr_width +: sram_addr_width];
    assign ch_addr[2*i+1] = cl_write_addr[i*sram_addr_width +: sram_addr_width];
    assign ch_data[2*i] = cl_write_data[i*data_width +: data_width];
    assign ch_data[2*i+1] = cl_write_data[i*data_width +: data_width];
    assign cl_read_ready[i] = rdy_q[2*i];
    assign cl_write_ready[i] = rdy_q[2*i+1];
    assign cl_read_invalid[i] = inv_q[2*i];
    assign cl_write_invalid[i] = inv_q[2*i+1];
  end
  function automatic logic [CW-1:0] rr_sel(input logic [NC-1:0] v, input logic [CW-1:0] s);
    logic [CW-1:0] r, j;
    r = s;
    for (int k = NC - 1; k >= 0; k--) begin
      j = CW'((int'(s) + k) % NC);
      if (v[j]) r = j;
    end
    return r;
  endfunction
  // a channel that just got its pulse still holds its request for that one cycle
  assign pend = req_ch & ~(rdy_q | inv_q);
`ifdef SRAM_ARB_WRITE_PRIORITY_EN
  localparam logic [NC-1:0] WMASK = {N_REQ{2'b10}};
  logic [CW-1:0] rr_w, rr_r;
  assign pick = |(pend & WMASK) ? rr_sel(pend & WMASK, rr_w) : rr_sel(pend, rr_r);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rr_w <= '0;
      rr_r <= '0;
    end else if ((grant && oob) || done) begin
      if (ch[0]) rr_w <= ch_nx;
      else rr_r <= ch_nx;
    end
`else
  logic [CW-1:0] rr;
  assign pick = rr_sel(pend, rr);
  always_ff @(posedge clk or negedge reset)
    if (!reset) rr <= '0;
    else if ((grant && oob) || done) rr <= ch_nx;
`endif
  assign addr_ext = 32'(ch_addr[pick]);
  assign oob = addr_ext >= 32'(sram_capacity);
  assign tmo = tcnt == TW'(timeout_cycles - 1);
  always_comb begin
    grant = state == IDLE && |pend;
    done = state == WAIT && (mem_err || mem_ack || tmo);
    ch = done ? cur : pick;
    ch_nx = ch == CW'(NC - 1) ? '0 : ch + 1'b1;
    state_nx = (grant && !oob) ? WAIT : (done ? IDLE : state);
    rdy_nx = (done && !mem_err && mem_ack) ? NC'(1) << cur : '0;
    inv_nx = (grant && oob) ? NC'(1) << pick : ((done && (mem_err || !mem_ack)) ? NC'(1) << cur : '0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cur <= '0;
      tcnt <= '0;
      rdy_q <= '0;
      inv_q <= '0;
      cl_read_data <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= rdy_nx;
      inv_q <= inv_nx;
      if (grant) cur <= pick;
      if (grant && !oob) begin
        mem_req <= 1'b1;
        mem_we <= pick[0];
        mem_addr <= ch_addr[pick];
        mem_wdata <= ch_data[pick];
        tcnt <= '0;
      end
      if (done) mem_req <= 1'b0;
      else if (state == WAIT) tcnt <= tcnt + 1'b1;
      if (|rdy_nx && !cur[0]) cl_read_data <= mem_rdata;
    end
endmodule
